cell_particle_reader: RTL and testbench

- Read controller that sits directly downstream of a per-cell position RAM (single-port, 2-cycle read latency, address 0 = particle count, addresses 1..N = {posz, posy, posx}).
- On start, fetches the count, then streams every particle record out over a ready/valid interface with backpressure.
- Feeds the position cache / force-evaluation front end.

---
 rtl/cell_reader_pkg.sv | 18 +
 rtl/cell_particle_reader_if.sv | 13 +
 rtl/cell_reader_fifo.sv | 42 ++++
 rtl/cell_particle_reader.sv | 109 ++++++++++
 tb/tb_cell_particle_reader.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cell_reader_pkg.sv
// cell_reader_pkg: FSM state codes, in-flight read tag and default sizing shared by the cell reader
package cell_reader_pkg;
  localparam int DEF_RD_LATENCY = 2;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int TAG_ID_W = 8;
  typedef logic [2:0] state_t;
  localparam state_t IDLE     = 3'd0;
  localparam state_t REQ_NUM  = 3'd1;
  localparam state_t WAIT_NUM = 3'd2;
  localparam state_t STREAM   = 3'd3;
  localparam state_t DRAIN    = 3'd4;
  localparam state_t FINISH   = 3'd5;
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                last;
  } tag_t;
endpackage

// File: rtl/cell_particle_reader_if.sv
// cell_particle_reader_if: ready/valid particle record stream from the reader to the force front end
interface cell_particle_reader_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_id;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  modport master (output out_data, out_id, out_valid, out_last, input out_ready);
  modport slave (input out_data, out_id, out_valid, out_last, output out_ready);
endinterface

// File: rtl/cell_reader_fifo.sv
// cell_reader_fifo: first-word-fall-through synchronous FIFO with occupancy count and async clear
module cell_reader_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_idx, rd_idx;
  logic full, do_wr, do_rd;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign rd_data = mem[rd_idx];
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] idx);
    return idx == AW'(DEPTH - 1) ? '0 : idx + 1'b1;
  endfunction
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) mem[wr_idx] <= wr_data;
      wr_idx <= do_wr ? nxt(wr_idx) : wr_idx;
      rd_idx <= do_rd ? nxt(rd_idx) : rd_idx;
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  // upstream credit accounting must make this unreachable
  a_no_overflow: assert property (@(posedge clock) disable iff (!rst_n) !(wr_en && full));
endmodule

// File: rtl/cell_particle_reader.sv
// cell_particle_reader: fetches a cell's particle count from position RAM, then streams every
// record through a credit-limited skid FIFO so backpressure never loses in-flight RAM reads
module cell_particle_reader
  import cell_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int RD_LATENCY   = DEF_RD_LATENCY,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_num,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_rden,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q,
  cell_particle_reader_if.master out_if
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = $clog2(RD_LATENCY + 1);
  localparam int FW = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_NUM = ADDR_WIDTH'(PARTICLE_NUM - 1);
  logic [1:0] rst_sync;
  logic rst_ni;
  state_t state;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [WW-1:0] wait_cnt;
  tag_t pipe [RD_LATENCY];
  tag_t new_tag, tail;
  logic [CW-1:0] in_flight, fifo_count;
  logic fifo_empty, issue, credit, drain_done, is_last;
  logic [ADDR_WIDTH-1:0] q_num, clamped;
  logic [FW-1:0] fifo_rd;
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_ni = rst_sync[1];
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + CW'(pipe[i].valid);
  end
  // a read may only issue if its record is guaranteed a FIFO slot when it lands
  assign credit = ({1'b0, fifo_count} + {1'b0, in_flight}) < (CW + 1)'(FIFO_DEPTH);
  assign is_last = rd_ptr == {1'b0, particle_num};
  assign issue = state == STREAM && rd_ptr <= {1'b0, particle_num} && credit;
  assign drain_done = in_flight == '0 && (fifo_empty || (fifo_count == CW'(1) && out_if.out_ready));
  assign q_num = ram_q[ADDR_WIDTH-1:0];
  assign clamped = q_num > MAX_NUM ? MAX_NUM : q_num;
  assign tail = pipe[RD_LATENCY-1];
  assign new_tag = '{valid: issue, id: TAG_ID_W'(rd_ptr[ADDR_WIDTH-1:0]), last: is_last};
  assign busy = state == REQ_NUM || state == WAIT_NUM || state == STREAM || state == DRAIN;
  assign done = state == FINISH;
  assign ram_rden = state == REQ_NUM || issue;
  assign ram_address = issue ? rd_ptr[ADDR_WIDTH-1:0] : '0;
  assign ram_wren = 1'b0;
  always_ff @(posedge clock or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      rd_ptr <= '0;
      wait_cnt <= '0;
      particle_num <= '0;
    end else begin
      case (state)
        IDLE: state <= start ? REQ_NUM : IDLE;
        REQ_NUM: begin
          state <= WAIT_NUM;
          wait_cnt <= '0;
        end
        WAIT_NUM:
          if (wait_cnt == WW'(RD_LATENCY - 1)) begin
            particle_num <= clamped;
            rd_ptr <= (ADDR_WIDTH + 1)'(1);
            state <= clamped == '0 ? FINISH : STREAM;
          end else wait_cnt <= wait_cnt + 1'b1;
        STREAM:
          if (issue) begin
            rd_ptr <= rd_ptr + 1'b1;
            state <= is_last ? DRAIN : STREAM;
          end
        DRAIN: state <= drain_done ? FINISH : DRAIN;
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clock or negedge rst_ni)
    if (!rst_ni) for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
    else begin
      pipe[0] <= new_tag;
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  cell_reader_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .rst_n   (rst_ni),
    .wr_en   (tail.valid),
    .wr_data ({ram_q, ADDR_WIDTH'(tail.id), tail.last}),
    .rd_en   (out_if.out_valid && out_if.out_ready),
    .rd_data (fifo_rd),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );
  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data = fifo_rd[FW-1 -: DATA_WIDTH];
  assign out_if.out_id = fifo_rd[ADDR_WIDTH:1];
  assign out_if.out_last = fifo_rd[0];
endmodule

// File: tb/tb_cell_particle_reader.sv
// tb_cell_particle_reader: random cell contents and backpressure checked against a queue-based model
module tb_cell_particle_reader;
  localparam int DW = 96, AW = 8, PN = 220, DEPTH = 4;
  logic clock = 0, rst_n = 1, start = 0;
  logic busy, done, ram_rden, ram_wren;
  logic [AW-1:0] particle_num, ram_address;
  logic [DW-1:0] ram_q = '0, q1 = '0;
  logic [DW-1:0] mem [256];
  cell_particle_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();
  cell_particle_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN), .RD_LATENCY(2), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .particle_num(particle_num), .ram_address(ram_address), .ram_rden(ram_rden),
    .ram_wren(ram_wren), .ram_q(ram_q), .out_if(ifc)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (ram_rden) q1 <= mem[ram_address];
    ram_q <= q1;
  end
  typedef struct {logic [DW-1:0] d; logic [AW-1:0] id; logic last;} rec_t;
  rec_t exp_q[$];
  int addr_q[$];
  int checks = 0, failures = 0, cyc = 0, ready_mode = 0, ph = 0;
  int done_cnt = 0, done_cyc = 0, first_hs = 0, last_hs = 0, hs_cnt = 0, outstanding = 0, max_addr = 0;
  logic held = 0;
  rec_t hold, e_m;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    ifc.out_ready = 1;
    forever begin
      @(posedge clock);
      #1;
      ifc.out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? pat[ph % 4] : 1'($urandom_range(0, 1));
      ph++;
    end
  end

  always @(negedge clock) begin
    if (!rst_n) begin
      outstanding = 0;
      held = 0;
    end else begin
      if (ram_rden) begin
        chk("read_addr", DW'(ram_address), addr_q.size() != 0 ? DW'(addr_q.pop_front()) : '1);
        if (ram_address != 0) begin
          chk("read_credit", DW'(outstanding < DEPTH), 1);
          outstanding++;
          if (int'(ram_address) > max_addr) max_addr = int'(ram_address);
        end
      end
      if (held && ifc.out_valid)
        chk("hold_stable", {ifc.out_data}, hold.d);
      if (ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_record id=%0d required=none", ifc.out_id);
        end else begin
          e_m = exp_q.pop_front();
          chk("rec_data", ifc.out_data, e_m.d);
          chk("rec_id", DW'(ifc.out_id), DW'(e_m.id));
          chk("rec_last", DW'(ifc.out_last), DW'(e_m.last));
        end
        if (hs_cnt == 0) first_hs = cyc;
        last_hs = cyc;
        hs_cnt++;
        outstanding--;
      end
      held = ifc.out_valid && !ifc.out_ready;
      hold.d = ifc.out_data;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", DW'(busy), 0);
        chk("pending_at_done", DW'(exp_q.size()), 0);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, DW'(busy), 0);
    chk({tag, "_done"}, DW'(done), 0);
    chk({tag, "_rden"}, DW'(ram_rden), 0);
    chk({tag, "_wren"}, DW'(ram_wren), 0);
    chk({tag, "_addr"}, DW'(ram_address), 0);
    chk({tag, "_num"}, DW'(particle_num), 0);
    chk({tag, "_valid"}, DW'(ifc.out_valid), 0);
    chk({tag, "_last"}, DW'(ifc.out_last), 0);
    chk({tag, "_data"}, ifc.out_data, 0);
    chk({tag, "_id"}, DW'(ifc.out_id), 0);
  endtask

  task automatic load(input int cnt_word, output int n);
    rec_t r;
    n = cnt_word > PN - 1 ? PN - 1 : cnt_word;
    mem[0] = {$urandom(), $urandom(), 24'($urandom()), 8'(cnt_word)};
    addr_q.push_back(0);
    for (int i = 1; i <= n; i++) begin
      mem[i] = {$urandom(), $urandom(), $urandom()};
      r.d = mem[i];
      r.id = AW'(i);
      r.last = i == n;
      exp_q.push_back(r);
      addr_q.push_back(i);
    end
    max_addr = 0;
    hs_cnt = 0;
  endtask

  task automatic run_cell(input int cnt_word, input int mode, input bit extra_start);
    int n, base, t0, t;
    load(cnt_word, n);
    ready_mode = mode;
    base = done_cnt;
    @(posedge clock);
    #1 start = 1;
    t0 = cyc;
    @(posedge clock);
    #1 start = 0;
    if (extra_start) begin
      repeat (2) @(posedge clock);
      #1 chk("busy_on_restart", DW'(busy), 1);
      start = 1;
      @(posedge clock);
      #1 start = 0;
    end
    for (t = 0; t < 3000 && done_cnt == base; t++) @(negedge clock);
    chk("done_seen", DW'(done_cnt > base), 1);
    chk("particle_num", DW'(particle_num), DW'(n));
    chk("reads_left", DW'(addr_q.size()), 0);
    chk("records_left", DW'(exp_q.size()), 0);
    if (n == 0) begin
      chk("empty_done_latency", DW'(done_cyc - t0), 4);
      chk("empty_no_records", DW'(hs_cnt), 0);
    end else begin
      chk("max_addr", DW'(max_addr), DW'(n));
      chk("done_after_last", DW'(done_cyc - last_hs), 1);
      if (mode == 0) chk("back_to_back", DW'(last_hs - first_hs), DW'(n - 1));
    end
    repeat (8) @(negedge clock);
    chk("done_once", DW'(done_cnt - base), 1);
  endtask

  task automatic reset_mid_stream();
    int n, t;
    load(12, n);
    ready_mode = 0;
    @(posedge clock);
    #1 start = 1;
    @(posedge clock);
    #1 start = 0;
    for (t = 0; t < 200 && hs_cnt < 3; t++) @(negedge clock);
    chk("mid_records_seen", DW'(hs_cnt >= 3), 1);
    #2 rst_n = 0;
    #1 check_zero("midrst");
    exp_q.delete();
    addr_q.delete();
    #20;
    @(posedge clock);
    #1 rst_n = 1;
    repeat (4) @(posedge clock);
  endtask

  initial begin
    #1 rst_n = 0;
    #3 check_zero("rst");
    #20;
    @(posedge clock);
    #1 rst_n = 1;
    repeat (4) @(posedge clock);
    run_cell(5, 0, 0);
    run_cell(0, 0, 0);
    run_cell(8, 1, 0);
    run_cell(250, 2, 0);
    run_cell(6, 0, 1);
    reset_mid_stream();
    run_cell(4, 2, 0);
    for (int k = 0; k < 3; k++) run_cell(int'($urandom_range(1, 40)), k % 3, 0);
    run_cell(219, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
